hazard_ctrl: RTL and testbench

- Central pipeline controller for the rrv 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Decides per cycle whether the pipeline stalls, inserts an EX bubble or flushes the front end, and drives the operand-forwarding selects for the ID/EX operand muxes.
- Sequences load-use stalls and taken-jump/branch flushes with a small FSM.
- Keeps saturating stall/flush event counters for debug.

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, jump flushes, operand-forward selects, debug counters.
// Control outputs are combinational from state and inputs; counters update on the clock edge.
module hazard_ctrl #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] rs2_addr_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_gpr_we,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_gpr_we,
  input  logic                  mem_is_load,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_gpr_we,
  input  logic                  jump_en,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [1:0]            fwd_sel_rs1,
  output logic [1:0]            fwd_sel_rs2,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;
  localparam int CW = 8;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            luh;
  logic            take_jump;
  logic            jump_acc;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    logic [1:0] sel;
    sel = 2'd0;
    if (rs != '0) begin
      if (mem_gpr_we && !mem_is_load && mem_rd_addr == rs) sel = 2'd1;
      else if (wb_gpr_we && wb_rd_addr == rs)              sel = 2'd2;
    end
    return sel;
  endfunction

  assign luh = ex_is_load && ex_gpr_we && (ex_rd_addr != '0) &&
               ((rs1_used_id && rs1_addr_id == ex_rd_addr) ||
                (rs2_used_id && rs2_addr_id == ex_rd_addr));

  // A jump in LSTALL is honoured like one in RUN; in FLUSH it is a dead NOP and ignored.
  assign take_jump = jump_en && (state_q != FLUSH);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jump_acc    = 1'b0;
    fwd_sel_rs1 = fwd_sel(rs1_addr_id);
    fwd_sel_rs2 = fwd_sel(rs2_addr_id);

    if (take_jump) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      jump_acc    = 1'b1;
      state_d     = RUN;
      if (FLUSH_CYCLES > 1) begin
        cnt_d   = CW'(FLUSH_CYCLES - 2);
        state_d = FLUSH;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (luh) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_d   = CW'(LOAD_STALL_CYCLES - 2);
              state_d = LSTALL;
            end
          end
        end
        LSTALL: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        FLUSH: begin
          flush_if_id = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = RUN;
      endcase
    end

    if (rst) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      fwd_sel_rs1 = 2'd0;
      fwd_sel_rs2 = 2'd0;
      jump_acc    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_if && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (jump_acc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: directed scenarios plus random traffic against a
// cycle-count reference model of stall/flush sequencing, forwarding and saturating counters.
module tb_hazard_ctrl;
  localparam int LOAD_STALL_CYCLES = 2;
  localparam int FLUSH_CYCLES      = 2;
  localparam int CNT_W             = 4;
  localparam int MAXC              = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exrd;
    logic       exwe, exld;
    logic [4:0] memrd;
    logic       memwe, memld;
    logic [4:0] wbrd;
    logic       wbwe;
    logic       jump;
  } stim_t;

  typedef struct packed {
    logic [4:0]       ctrl;  // stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex
    logic [3:0]       fwd;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1_addr_id = '0, rs2_addr_id = '0, ex_rd_addr = '0, mem_rd_addr = '0, wb_rd_addr = '0;
  logic rs1_used_id = 1'b0, rs2_used_id = 1'b0, ex_gpr_we = 1'b0, ex_is_load = 1'b0;
  logic mem_gpr_we = 1'b0, mem_is_load = 1'b0, wb_gpr_we = 1'b0, jump_en = 1'b0;
  logic stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex;
  logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  // Reference model: remaining stall/flush cycles and event totals.
  int rem_stall = 0, rem_flush = 0, m_scnt = 0, m_fcnt = 0;

  hazard_ctrl #(
    .REG_ADDR_W(5), .LOAD_STALL_CYCLES(LOAD_STALL_CYCLES),
    .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .ex_rd_addr(ex_rd_addr), .ex_gpr_we(ex_gpr_we), .ex_is_load(ex_is_load),
    .mem_rd_addr(mem_rd_addr), .mem_gpr_we(mem_gpr_we), .mem_is_load(mem_is_load),
    .wb_rd_addr(wb_rd_addr), .wb_gpr_we(wb_gpr_we), .jump_en(jump_en),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] fwd_model(input logic [4:0] rs, input stim_t s);
    if (rs == 5'd0) return 2'd0;
    if (s.memwe && !s.memld && s.memrd == rs) return 2'd1;
    if (s.wbwe && s.wbrd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic hit(input logic [4:0] rd, input logic we, input logic ld, input stim_t s);
    return ld && we && rd != 5'd0 && ((s.u1 && s.rs1 == rd) || (s.u2 && s.rs2 == rd));
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic [4:0] ctrl;
    @(posedge clk); #1;
    rst = s.rst; rs1_addr_id = s.rs1; rs2_addr_id = s.rs2;
    rs1_used_id = s.u1; rs2_used_id = s.u2;
    ex_rd_addr = s.exrd; ex_gpr_we = s.exwe; ex_is_load = s.exld;
    mem_rd_addr = s.memrd; mem_gpr_we = s.memwe; mem_is_load = s.memld;
    wb_rd_addr = s.wbrd; wb_gpr_we = s.wbwe; jump_en = s.jump;
    e.scnt = CNT_W'(m_scnt);
    e.fcnt = CNT_W'(m_fcnt);
    ctrl = 5'b0;
    e.fwd = 4'b0;
    if (s.rst) begin
      rem_stall = 0; rem_flush = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (rem_stall == 0 && rem_flush == 0 && hit(s.memrd, s.memwe, s.memld, s)) begin
        failures++;
        $display("FAIL mluh_in_run: load in MEM matched ID source outside a stall, rd=%0d", s.memrd);
      end
      e.fwd = {fwd_model(s.rs1, s), fwd_model(s.rs2, s)};
      if (rem_flush > 0) begin
        ctrl = 5'b00010;
        rem_flush--;
      end else if (s.jump) begin
        ctrl = 5'b00011;
        rem_stall = 0;
        rem_flush = FLUSH_CYCLES - 1;
        if (m_fcnt < MAXC) m_fcnt++;
      end else if (rem_stall > 0 || hit(s.exrd, s.exwe, s.exld, s)) begin
        ctrl = 5'b11100;
        rem_stall = (rem_stall > 0) ? rem_stall - 1 : LOAD_STALL_CYCLES - 1;
        if (m_scnt < MAXC) m_scnt++;
      end
    end
    e.ctrl = ctrl;
    exp_q.push_back(e);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = ($urandom_range(0, 99) == 0);
    s.rs1   = 5'($urandom_range(0, 7));
    s.rs2   = 5'($urandom_range(0, 7));
    s.u1    = 1'($urandom);
    s.u2    = 1'($urandom);
    s.exrd  = 5'($urandom_range(0, 7));
    s.exwe  = ($urandom_range(0, 3) != 0);
    s.exld  = ($urandom_range(0, 2) == 0);
    s.memrd = 5'($urandom_range(0, 7));
    s.memwe = ($urandom_range(0, 3) != 0);
    s.memld = ($urandom_range(0, 3) == 0);
    s.wbrd  = 5'($urandom_range(0, 7));
    s.wbwe  = ($urandom_range(0, 3) != 0);
    s.jump  = ($urandom_range(0, 9) == 0);
    // A load in MEM feeding ID is only legal while a load-use stall is being sequenced.
    if (rem_stall == 0 && rem_flush == 0 && hit(s.memrd, s.memwe, s.memld, s)) s.memld = 1'b0;
    return s;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex} !== e.ctrl) begin
        failures++;
        $display("FAIL ctrl @%0t: got %b want %b", $time,
                 {stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex}, e.ctrl);
      end
      checks++;
      if ({fwd_sel_rs1, fwd_sel_rs2} !== e.fwd) begin
        failures++;
        $display("FAIL fwd @%0t: got rs1=%0d rs2=%0d want rs1=%0d rs2=%0d", $time,
                 fwd_sel_rs1, fwd_sel_rs2, e.fwd[3:2], e.fwd[1:0]);
      end
      checks++;
      if (stall_cnt !== e.scnt) begin
        failures++;
        $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, e.scnt);
      end
      checks++;
      if (flush_cnt !== e.fcnt) begin
        failures++;
        $display("FAIL flush_cnt @%0t: got %0d want %0d", $time, flush_cnt, e.fcnt);
      end
    end
  end

  initial begin
    stim_t s, lu;
    // Bring counters out of X before anything is scored.
    repeat (2) @(posedge clk);

    // Reset held with a jump and a load-use hazard present.
    lu = '0;
    lu.exld = 1'b1; lu.exwe = 1'b1; lu.exrd = 5'd5; lu.u1 = 1'b1; lu.rs1 = 5'd5; lu.rs2 = 5'd1;
    s = lu; s.rst = 1'b1; s.jump = 1'b1;
    repeat (3) step(s);
    step('0);

    // Load-use: lw x5 in EX, then in MEM, then in WB feeding add x6,x5,x1.
    step(lu);
    s = '0; s.u1 = 1'b1; s.rs1 = 5'd5; s.rs2 = 5'd1; s.memrd = 5'd5; s.memwe = 1'b1; s.memld = 1'b1;
    step(s);
    s = '0; s.u1 = 1'b1; s.rs1 = 5'd5; s.rs2 = 5'd1; s.wbrd = 5'd5; s.wbwe = 1'b1;
    step(s);

    // Forward priority: MEM over WB, then WB alone, then x0.
    s = '0; s.u2 = 1'b1; s.rs2 = 5'd7; s.memrd = 5'd7; s.memwe = 1'b1; s.wbrd = 5'd7; s.wbwe = 1'b1;
    step(s);
    s.memwe = 1'b0;
    step(s);
    s.rs2 = 5'd0; s.rs1 = 5'd0; s.memrd = 5'd0; s.memwe = 1'b1; s.wbrd = 5'd0;
    step(s);

    // Single-cycle jump, then jump coincident with a load-use hazard.
    s = '0; s.jump = 1'b1;
    step(s);
    repeat (2) step('0);
    s = lu; s.jump = 1'b1;
    step(s);
    repeat (2) step('0);

    for (int i = 0; i < 600; i++) step(rand_stim());

    // Saturation: 20 load-use hazards from a clean reset.
    s = '0; s.rst = 1'b1;
    step(s);
    for (int i = 0; i < 20; i++) begin
      step(lu);
      step('0);
      step('0);
    end

    // Reset landing in the middle of a load-use stall.
    step(lu);
    s = lu; s.rst = 1'b1;
    step(s);
    repeat (2) step('0);

    for (int i = 0; i < 300; i++) step(rand_stim());

    @(posedge clk);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected responses never compared, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
